// File: rtl/acc_lsu_mem_responder.sv
// ---------------------------------------------------------------------------
// acc_lsu_mem_responder
//
// Memory-side responder for one accelerator LSU port. It accepts 64-bit
// read and byte-masked write requests over a valid/ready handshake. A
// word-wide SRAM array backs the requests. Each accepted request gets
// exactly one response, in order, a fixed RSP_LATENCY cycles later.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous, active-low reset
//   req_valid_i  request valid
//   req_addr_i   byte address of the request
//   req_wmask_i  byte-lane write enables, bit i covers data[8i+7:8i]
//   req_data_i   write data
//   req_cmd_i    1 = write, 0 = read
//   req_ready_o  request can be accepted this cycle (just !stall_i)
//   stall_i      back-pressure from the bench or arbiter
//   rsp_valid_o  response valid, one cycle per response
//   rsp_data_o   read data, 0 for writes, errors and idle cycles
//   rsp_err_o    response error flag
//   err_cnt_o    saturating count of error responses
// ---------------------------------------------------------------------------
module acc_lsu_mem_responder #(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            DATA_WIDTH  = 64,
    parameter int unsigned            MEM_DEPTH   = 4096,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
    parameter int unsigned            RSP_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [7:0]            req_wmask_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic                  req_cmd_i,
    output logic                  req_ready_o,
    input  logic                  stall_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic [15:0]           err_cnt_o
);

    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned NUM_LANES = 8;

    // Reject parameter combinations the datapath cannot represent.
    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("acc_lsu_mem_responder: DATA_WIDTH must be 64");
    end
    if (RSP_LATENCY < 1 || RSP_LATENCY > 8) begin : g_bad_latency
        $error("acc_lsu_mem_responder: RSP_LATENCY must be in 1..8");
    end
    if (BASE_ADDR[2:0] != 3'b000) begin : g_bad_base
        $error("acc_lsu_mem_responder: BASE_ADDR must be 8-byte aligned");
    end
    if (IDX_W + 3 > ADDR_WIDTH) begin : g_bad_depth
        $error("acc_lsu_mem_responder: MEM_DEPTH does not fit in ADDR_WIDTH");
    end

    // Backing store. It is left unreset on purpose, and benches reach it
    // hierarchically as mem.
    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    logic                  accept;
    logic [ADDR_WIDTH:0]   offset_ext;
    logic                  below_base;
    logic                  misaligned;
    logic                  beyond_end;
    logic                  addr_err;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] stage1_data;
    logic                  launch_err;
    logic [15:0]           err_cnt;

    logic [RSP_LATENCY:1]  pipe_valid;
    logic [RSP_LATENCY:1]  pipe_err;
    logic [DATA_WIDTH-1:0] pipe_data [1:RSP_LATENCY];

    assign req_ready_o = !stall_i;
    assign accept      = req_valid_i && req_ready_o;

    // Subtract the base with one extra bit. The borrow out flags addresses
    // below BASE_ADDR without needing a magnitude compare against a
    // constant. Because the base is 8-byte aligned, the low offset bits
    // equal the low address bits.
    assign offset_ext = {1'b0, req_addr_i} - {1'b0, BASE_ADDR};
    assign below_base = offset_ext[ADDR_WIDTH];
    assign misaligned = |offset_ext[2:0];
    assign beyond_end = {3'b000, offset_ext[ADDR_WIDTH-1:3]} >= ADDR_WIDTH'(MEM_DEPTH);
    assign addr_err   = below_base || misaligned || beyond_end;
    assign word_idx   = offset_ext[IDX_W+2:3];

    // Read data is captured at the acceptance edge. Writes, error requests
    // and empty cycles carry zero down the pipe, so the outputs are already
    // zero whenever no valid read response is being presented.
    always_comb begin
        stage1_data = '0;
        if (accept && !req_cmd_i && !addr_err) begin
            stage1_data = mem[word_idx];
        end
    end

    // Array update with per-byte lane enables. An erroring request never
    // writes, and an all-zero mask simply leaves the word untouched.
    always_ff @(posedge clk_i) begin
        if (accept && req_cmd_i && !addr_err) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (req_wmask_i[b]) begin
                    mem[word_idx][8*b +: 8] <= req_data_i[8*b +: 8];
                end
            end
        end
    end

    // Fixed-depth response pipeline. Stage 1 captures the accepted request
    // and every stage shifts each cycle. Stall does not freeze it, so
    // acceptance gaps reappear unchanged at the output. Reset drops every
    // in-flight entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int k = 1; k <= RSP_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_valid[1] <= accept;
            pipe_err[1]   <= accept && addr_err;
            pipe_data[1]  <= stage1_data;
            for (int k = 2; k <= RSP_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_err[k]   <= pipe_err[k-1];
                pipe_data[k]  <= pipe_data[k-1];
            end
        end
    end

    // The error counter steps on the same edge that puts an error response
    // onto the outputs. It therefore looks at whatever feeds the last
    // stage. That is the raw request when the pipe is only one stage deep.
    if (RSP_LATENCY == 1) begin : g_launch_direct
        assign launch_err = accept && addr_err;
    end else begin : g_launch_piped
        assign launch_err = pipe_err[RSP_LATENCY-1];
    end

    // Saturating error counter. It sticks at 0xFFFF instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt <= '0;
        end else if (launch_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    assign rsp_valid_o = pipe_valid[RSP_LATENCY];
    assign rsp_err_o   = pipe_err[RSP_LATENCY];
    assign rsp_data_o  = pipe_data[RSP_LATENCY];
    assign err_cnt_o   = err_cnt;

endmodule
